// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared widths, result layout and helpers for the fixed-to-float converter
package fpcvt_pkg;
  localparam int D_W = 13;
  localparam int E_W = 3;
  localparam int F_W = 5;
  localparam int R_W = 1 + E_W + F_W;
  localparam int R_S = R_W - 1;
  localparam int R_E_LSB = F_W;
  localparam int R_F_LSB = 0;
  typedef struct packed {
    logic s;
    logic [E_W-1:0] e;
    logic [F_W-1:0] f;
  } res_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fpcvt_core.sv
// fpcvt_core: combinational 13-bit two's-complement to S/E[2:0]/F[4:0] with round-to-nearest
// out sat port present only when FPCVT_SAT_FLAG_EN is defined
module fpcvt_core
  import fpcvt_pkg::*;
(
  input  logic [D_W-1:0] d,
  output res_t           res
`ifdef FPCVT_SAT_FLAG_EN
  ,
  output logic           sat
`endif
);
  logic [11:0] mag;
  logic [3:0] msb, e_raw;
  logic [4:0] f0;
  logic [5:0] sum;
  logic rb, ovf, sat_i;
  always_comb begin
    mag = d == 13'h1000 ? 12'hfff : 12'(d[12] ? -d : d);
    msb = '0;
    for (int i = 0; i < 12; i++) msb = mag[i] ? 4'(i) : msb;
    e_raw = |mag[11:4] ? msb - 4'd3 : 4'd0;
    f0 = 5'(mag >> e_raw);
    rb = e_raw != 4'd0 && mag[e_raw - 4'd1];
    sum = {1'b0, f0} + {5'd0, rb};
    ovf = sum[5];
    // an exponent of 8 cannot be encoded, so it saturates like a rounding overflow at 7
    sat_i = e_raw[3] || (ovf && e_raw == 4'd7);
    res.s = d[12];
    res.e = sat_i ? 3'd7 : ovf ? e_raw[2:0] + 3'd1 : e_raw[2:0];
    res.f = sat_i ? 5'd31 : ovf ? 5'd16 : sum[4:0];
  end
`ifdef FPCVT_SAT_FLAG_EN
  assign sat = sat_i;
`endif
endmodule

// File: rtl/fpcvt_rr_scheduler.sv
// fpcvt_rr_scheduler: round-robin shares one fpcvt_core among N_REQ requesters, 2-stage pipeline
// defining FPCVT_SAT_FLAG_EN adds the out_sat port
module fpcvt_rr_scheduler
  import fpcvt_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [D_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_s,
  output logic [E_W-1:0]         out_e,
  output logic [F_W-1:0]         out_f
`ifdef FPCVT_SAT_FLAG_EN
  ,
  output logic                   out_sat
`endif
);
  if (ID_W != clog2(N_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(N_REQ)");
  end
  logic [ID_W-1:0] ptr, gnt, s0_id;
  logic [D_W-1:0] s0_d, d_sel;
  logic found, adv, acc, s0_v;
  res_t res;
`ifdef FPCVT_SAT_FLAG_EN
  logic sat;
  fpcvt_core u_core (.d(s0_d), .res(res), .sat(sat));
`else
  fpcvt_core u_core (.d(s0_d), .res(res));
`endif
  always_comb begin
    found = 1'b0;
    gnt = ptr;
    // lowest valid overall is the wrap-around fallback; lowest valid above ptr overrides it
    for (int i = N_REQ - 1; i >= 0; i--) begin
      found = found || req_valid[i];
      gnt = req_valid[i] ? ID_W'(i) : gnt;
    end
    for (int i = N_REQ - 1; i >= 0; i--) gnt = (req_valid[i] && ID_W'(i) > ptr) ? ID_W'(i) : gnt;
    d_sel = '0;
    for (int i = 0; i < N_REQ; i++) d_sel = ID_W'(i) == gnt ? req_data[D_W*i +: D_W] : d_sel;
    adv = !out_valid || out_ready;
    acc = found && adv;
    req_ready = acc ? N_REQ'(1) << gnt : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(N_REQ - 1);
      s0_v <= 1'b0;
      s0_d <= '0;
      s0_id <= '0;
      out_valid <= 1'b0;
      out_id <= '0;
      out_s <= 1'b0;
      out_e <= '0;
      out_f <= '0;
`ifdef FPCVT_SAT_FLAG_EN
      out_sat <= 1'b0;
`endif
    end else if (adv) begin
      ptr <= acc ? gnt : ptr;
      s0_v <= acc;
      s0_d <= d_sel;
      s0_id <= gnt;
      out_valid <= s0_v;
      out_id <= s0_id;
      out_s <= res.s;
      out_e <= res.e;
      out_f <= res.f;
`ifdef FPCVT_SAT_FLAG_EN
      out_sat <= sat;
`endif
    end
  end
endmodule

// File: tb/tb_fpcvt_rr_scheduler.sv
// tb_fpcvt_rr_scheduler: randomized bench with a queue-based reference model plus literal checks
module tb_fpcvt_rr_scheduler;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [13*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic out_valid, out_s;
  logic [1:0] out_id;
  logic [2:0] out_e;
  logic [4:0] out_f;
`ifdef FPCVT_SAT_FLAG_EN
  logic out_sat;
`endif
  int checks = 0, errors = 0;

  fpcvt_rr_scheduler #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_s(out_s),
    .out_e(out_e), .out_f(out_f)
`ifdef FPCVT_SAT_FLAG_EN
    , .out_sat(out_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // result = {sat, s, e[2:0], f[4:0]} from value = f * 2^e, rounding half up
  function automatic logic [9:0] conv(logic [12:0] d);
    int v, mag, e, f;
    logic s;
    s = d[12];
    v = d[12] ? int'(d) - 8192 : int'(d);
    mag = v < 0 ? -v : v;
    if (mag > 4095) mag = 4095;
    e = 0;
    while (e < 8 && mag >= (16 << e)) e++;
    if (e == 8) return {1'b1, s, 3'd7, 5'd31};
    f = e == 0 ? mag : (mag + (1 << (e - 1))) >> e;
    if (f > 31) begin
      if (e == 7) return {1'b1, s, 3'd7, 5'd31};
      f = 16;
      e++;
    end
    return {1'b0, s, 3'(e), 5'(f)};
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  typedef struct {
    int id;
    logic [9:0] r;
    int ts;
  } ent_t;
  ent_t q[$];
  int m_ptr = N - 1;
  int cyc = 0;

  function automatic bit head_vis();
    return q.size() > 0 && q[0].ts <= cyc;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit hv;
    int g;
    if (rst) begin
      q.delete();
      m_ptr = N - 1;
    end else begin
      hv = head_vis();
      g = pick(req_valid, m_ptr);
      if (hv && out_ready) void'(q.pop_front());
      if (g >= 0 && (!hv || out_ready)) begin
        q.push_back('{g, conv(req_data[13*g +: 13]), cyc + 2});
        m_ptr = g;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit hv;
    int g;
    if (!rst) begin
      hv = head_vis();
      g = pick(req_valid, m_ptr);
      chk("out_valid", 32'(out_valid), 32'(hv));
      if (hv) begin
        chk("out_id", 32'(out_id), 32'(q[0].id));
        chk("out_s", 32'(out_s), 32'(q[0].r[8]));
        chk("out_e", 32'(out_e), 32'(q[0].r[7:5]));
        chk("out_f", 32'(out_f), 32'(q[0].r[4:0]));
`ifdef FPCVT_SAT_FLAG_EN
        chk("out_sat", 32'(out_sat), 32'(q[0].r[9]));
`endif
      end
      chk("req_ready", 32'(req_ready), (g >= 0 && (!hv || out_ready)) ? 32'(1) << g : 32'(0));
    end
  end

  task automatic lit(int i, logic [12:0] d, int es, int ee, int ef, int esat);
    @(posedge clk); #2;
    out_ready = 1'b1;
    req_valid = 4'(1 << i);
    req_data = '0;
    req_data[13*i +: 13] = d;
    @(negedge clk);
    chk("lit_ready", 32'(req_ready), 32'(1) << i);
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk);
    chk("lit_latency", 32'(out_valid), 0);
    @(negedge clk);
    chk("lit_valid", 32'(out_valid), 1);
    chk("lit_id", 32'(out_id), 32'(i));
    chk("lit_s", 32'(out_s), 32'(es));
    chk("lit_e", 32'(out_e), 32'(ee));
    chk("lit_f", 32'(out_f), 32'(ef));
`ifdef FPCVT_SAT_FLAG_EN
    chk("lit_sat", 32'(out_sat), 32'(esat));
`else
    if (esat < 0) $display("unexpected esat");
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  function automatic logic [12:0] rnd_d();
    logic [12:0] c[6] = '{13'h0000, 13'h0001, 13'h0FFF, 13'h1000, 13'h1FFF, 13'h07FF};
    return $urandom_range(0, 7) == 0 ? c[$urandom_range(0, 5)] : 13'($urandom());
  endfunction

  function automatic logic [13*N-1:0] rnd_bus();
    logic [13*N-1:0] b;
    for (int i = 0; i < N; i++) b[13*i +: 13] = rnd_d();
    return b;
  endfunction

  initial begin
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_e", 32'(out_e), 0);
    chk("rst_f", 32'(out_f), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    lit(0, 13'h006C, 0, 3, 14, 0);
    lit(1, 13'h0FFF, 0, 7, 31, 1);
    lit(2, 13'h1000, 1, 7, 31, 1);
    lit(3, 13'h0000, 0, 0, 0, 0);
    lit(0, 13'h0001, 0, 0, 1, 0);
    lit(1, 13'h006F, 0, 3, 14, 0);
    lit(2, 13'h1F94, 1, 3, 14, 0);
    lit(3, 13'h07FF, 0, 7, 16, 0);
    lit(0, 13'h0010, 0, 1, 8, 0);
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      req_data = rnd_bus();
      @(negedge clk);
      chk("rr_order", 32'(req_ready), 32'(1) << (k % 4));
      @(posedge clk); #2;
    end
    for (int k = 0; k < 15; k++) begin
      req_data = rnd_bus();
      out_ready = !(k >= 4 && k < 9);
      @(negedge clk);
      if (k >= 4 && k < 9) chk("stall_ready", 32'(req_ready), 0);
      @(posedge clk); #2;
    end
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom());
      req_data = rnd_bus();
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #2;
    end
    do_reset();
    out_ready = 1'b1;
    req_valid = '1;
    req_data = rnd_bus();
    @(posedge clk); #2;
    @(posedge clk); #2;
    req_valid = '0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 1);
    @(posedge clk); #2;
    req_valid = '0;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
